// File: rtl/ifetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encodings and word constants.
package ifetch_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StFull  = 3'd3,
    StDrain = 3'd4
  } fetch_state_e;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: one outstanding bus read, a single-entry instruction
// buffer towards decode, and flush handling for requests both in flight and unaccepted.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        stallreq_o
);

  fetch_state_e state_q, state_d;
  logic         flush_pend_q, flush_pend_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  inst_q, inst_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      flush_pend_q <= 1'b0;
      addr_q       <= ZeroWord;
      inst_q       <= ZeroWord;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      addr_q       <= addr_d;
      inst_q       <= inst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    addr_d       = addr_q;
    inst_d       = inst_q;
    unique case (state_q)
      StIdle: begin
        if (ce_i && !flush_i) begin
          state_d = StReq;
          addr_d  = pc_i;
        end
      end
      StReq: begin
        // A request is never withdrawn; a flush seen before acceptance is remembered.
        if (inst_addr_ok_i) begin
          state_d = (flush_i || flush_pend_q) ? StDrain : StWait;
        end else if (flush_i) begin
          flush_pend_d = 1'b1;
        end
      end
      StWait: begin
        if (inst_data_ok_i) begin
          if (flush_i || flush_pend_q) begin
            state_d      = StIdle;
            flush_pend_d = 1'b0;
          end else begin
            state_d = StFull;
            inst_d  = inst_rdata_i;
          end
        end else if (flush_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (inst_data_ok_i) begin
          state_d      = StIdle;
          flush_pend_d = 1'b0;
        end
      end
      StFull: begin
        if (flush_i || !stall_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d      = StIdle;
        flush_pend_d = 1'b0;
      end
    endcase
  end

  // Outputs decode registered state only; stallreq_o must not see stall_i or flush_i.
  always_comb begin
    inst_req_o   = (state_q == StReq);
    inst_addr_o  = addr_q;
    inst_o       = inst_q;
    inst_valid_o = (state_q == StFull);
    stallreq_o   = ce_i && (state_q != StFull);
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: per-cycle stimulus/expectation table fed through a scoreboard
// queue, plus hand-written asynchronous-reset sequences.
module tb_ifetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        stall_i;
  logic        flush_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stallreq_o;

  ifetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .ce_i          (ce_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .inst_req_o    (inst_req_o),
    .inst_addr_o   (inst_addr_o),
    .inst_addr_ok_i(inst_addr_ok_i),
    .inst_data_ok_i(inst_data_ok_i),
    .inst_rdata_i  (inst_rdata_i),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o),
    .stallreq_o    (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic        stall;
    logic        flush;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic        e_sreq;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Inputs for one cycle and the outputs expected during that same cycle.
  task automatic add(input logic ce, input logic stall, input logic flush, input logic aok,
                     input logic dok, input logic [31:0] rdata, input logic [31:0] pc,
                     input logic req, input logic [31:0] addr, input logic valid,
                     input logic [31:0] inst, input logic sreq);
    vec_t v;
    v.ce = ce; v.stall = stall; v.flush = flush; v.aok = aok; v.dok = dok;
    v.rdata = rdata; v.pc = pc;
    v.e_req = req; v.e_addr = addr; v.e_valid = valid; v.e_inst = inst; v.e_sreq = sreq;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ce, input logic stall, input logic flush, input logic aok,
                       input logic dok, input logic [31:0] rdata, input logic [31:0] pc);
    ce_i = ce; stall_i = stall; flush_i = flush; inst_addr_ok_i = aok;
    inst_data_ok_i = dok; inst_rdata_i = rdata; pc_i = pc;
  endtask

  initial begin
    vec_t e;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    //  ce st fl aok dok rdata         pc             req addr          val inst          sreq
    // Basic fetch, then decode hold for 4 cycles, then consume.
    add(1, 0, 0, 0, 0, 32'h0,        32'hBFC00000, 0, 32'h0,        0, 32'h0,        1);
    add(1, 0, 0, 1, 0, 32'h0,        32'hBFC00000, 1, 32'hBFC00000, 0, 32'h0,        1);
    add(1, 0, 0, 0, 1, 32'h24010001, 32'hBFC00000, 0, 32'hBFC00000, 0, 32'h0,        1);
    for (int i = 0; i < 4; i++)
      add(1, 1, 0, 0, 0, 32'h0,      32'hBFC00004, 0, 32'hBFC00000, 1, 32'h24010001, 0);
    add(1, 0, 0, 0, 0, 32'h0,        32'hBFC00004, 0, 32'hBFC00000, 1, 32'h24010001, 0);
    add(1, 0, 0, 0, 0, 32'h0,        32'hBFC00004, 0, 32'hBFC00000, 0, 32'h24010001, 1);
    // Slow bus: addr_ok held off for 5 cycles.
    for (int i = 0; i < 5; i++)
      add(1, 0, 0, 0, 0, 32'h0,      32'hBFC00004, 1, 32'hBFC00004, 0, 32'h24010001, 1);
    add(1, 0, 0, 1, 0, 32'h0,        32'hBFC00004, 1, 32'hBFC00004, 0, 32'h24010001, 1);
    add(1, 0, 0, 0, 0, 32'h0,        32'hBFC00004, 0, 32'hBFC00004, 0, 32'h24010001, 1);
    add(1, 0, 0, 0, 1, 32'h8C020010, 32'hBFC00004, 0, 32'hBFC00004, 0, 32'h24010001, 1);
    add(1, 0, 0, 0, 0, 32'h0,        32'hBFC00008, 0, 32'hBFC00004, 1, 32'h8C020010, 0);
    // ce low in IDLE with stray data_ok: ignored.
    add(0, 0, 0, 0, 1, 32'hDEADBEEF, 32'hBFC00008, 0, 32'hBFC00004, 0, 32'h8C020010, 0);
    add(1, 0, 0, 0, 0, 32'h0,        32'hBFC00008, 0, 32'hBFC00004, 0, 32'h8C020010, 1);
    // Flush in WAIT: returned word dropped, next request from flushed PC.
    add(1, 0, 0, 1, 0, 32'h0,        32'hBFC00008, 1, 32'hBFC00008, 0, 32'h8C020010, 1);
    add(1, 0, 1, 0, 0, 32'h0,        32'hBFC00380, 0, 32'hBFC00008, 0, 32'h8C020010, 1);
    add(1, 0, 0, 0, 1, 32'h11111111, 32'hBFC00380, 0, 32'hBFC00008, 0, 32'h8C020010, 1);
    add(1, 0, 0, 0, 0, 32'h0,        32'hBFC00380, 0, 32'hBFC00008, 0, 32'h8C020010, 1);
    add(1, 0, 0, 1, 0, 32'h0,        32'hBFC00380, 1, 32'hBFC00380, 0, 32'h8C020010, 1);
    add(1, 0, 0, 0, 1, 32'h22222222, 32'hBFC00380, 0, 32'hBFC00380, 0, 32'h8C020010, 1);
    // Flush together with consume in FULL, flush held a cycle in IDLE: no issue.
    add(1, 0, 1, 0, 0, 32'h0,        32'hBFC00400, 0, 32'hBFC00380, 1, 32'h22222222, 0);
    add(1, 0, 1, 0, 0, 32'h0,        32'hBFC00400, 0, 32'hBFC00380, 0, 32'h22222222, 1);
    add(1, 0, 0, 0, 0, 32'h0,        32'hBFC00400, 0, 32'hBFC00380, 0, 32'h22222222, 1);
    // Flush during unaccepted request: held until addr_ok, then drained.
    add(1, 0, 1, 0, 0, 32'h0,        32'hBFC00400, 1, 32'hBFC00400, 0, 32'h22222222, 1);
    add(1, 0, 0, 0, 1, 32'h33333333, 32'hBFC00400, 1, 32'hBFC00400, 0, 32'h22222222, 1);
    add(1, 0, 0, 1, 0, 32'h0,        32'hBFC00400, 1, 32'hBFC00400, 0, 32'h22222222, 1);
    add(1, 0, 0, 0, 0, 32'h0,        32'hBFC00400, 0, 32'hBFC00400, 0, 32'h22222222, 1);
    add(1, 0, 0, 0, 1, 32'h44444444, 32'hBFC00400, 0, 32'hBFC00400, 0, 32'h22222222, 1);
    add(0, 0, 0, 0, 0, 32'h0,        32'hBFC00500, 0, 32'hBFC00400, 0, 32'h22222222, 0);
    // Pending flush must be cleared: this fetch completes normally.
    add(1, 0, 0, 0, 0, 32'h0,        32'hBFC00500, 0, 32'hBFC00400, 0, 32'h22222222, 1);
    add(1, 0, 0, 1, 0, 32'h0,        32'hBFC00500, 1, 32'hBFC00500, 0, 32'h22222222, 1);
    add(1, 0, 0, 0, 1, 32'h55555555, 32'hBFC00500, 0, 32'hBFC00500, 0, 32'h22222222, 1);
    add(1, 0, 0, 0, 0, 32'h0,        32'hBFC00600, 0, 32'hBFC00500, 1, 32'h55555555, 0);
    // ce drops mid-transaction: transaction still completes, then stays idle.
    add(1, 0, 0, 0, 0, 32'h0,        32'hBFC00600, 0, 32'hBFC00500, 0, 32'h55555555, 1);
    add(0, 0, 0, 1, 0, 32'h0,        32'hBFC00600, 1, 32'hBFC00600, 0, 32'h55555555, 0);
    add(0, 0, 0, 0, 1, 32'h66666666, 32'hBFC00600, 0, 32'hBFC00600, 0, 32'h55555555, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'hBFC00604, 0, 32'hBFC00600, 1, 32'h66666666, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'hBFC00604, 0, 32'hBFC00600, 0, 32'h66666666, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'hBFC00604, 0, 32'hBFC00600, 0, 32'h66666666, 0);

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",   {31'b0, inst_req_o},   32'h0);
    check("rst_valid", {31'b0, inst_valid_o}, 32'h0);
    check("rst_addr",  inst_addr_o,           32'h0);
    check("rst_inst",  inst_o,                32'h0);
    check("rst_sreq",  {31'b0, stallreq_o},   32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Table: expectations queued when stimulus is driven, popped when outputs are sampled.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].ce, vecs[i].stall, vecs[i].flush, vecs[i].aok, vecs[i].dok,
            vecs[i].rdata, vecs[i].pc);
      exp_q.push_back(vecs[i]);
      #1;
      e = exp_q.pop_front();
      check($sformatf("v%0d_req", i),   {31'b0, inst_req_o},   {31'b0, e.e_req});
      check($sformatf("v%0d_addr", i),  inst_addr_o,           e.e_addr);
      check($sformatf("v%0d_valid", i), {31'b0, inst_valid_o}, {31'b0, e.e_valid});
      check($sformatf("v%0d_inst", i),  inst_o,                e.e_inst);
      check($sformatf("v%0d_sreq", i),  {31'b0, stallreq_o},   {31'b0, e.e_sreq});
    end

    // Async reset while waiting for data.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 32'h0, 32'hBFC00700);
    @(negedge clk);
    drive(1, 0, 0, 1, 0, 32'h0, 32'hBFC00700);
    #1;
    check("wait_pre_req", {31'b0, inst_req_o}, 32'h1);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 32'h0, 32'hBFC00700);
    #2;
    rst = 1'b0;
    #1;
    check("arst_wait_req",   {31'b0, inst_req_o},   32'h0);
    check("arst_wait_valid", {31'b0, inst_valid_o}, 32'h0);
    check("arst_wait_addr",  inst_addr_o,           32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 32'h0, 32'hBFC00000);
    rst = 1'b1;

    // First request after reset one edge after ce, then fill and reset from FULL.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 32'h0, 32'hBFC00000);
    #1;
    check("post_rst_idle_req", {31'b0, inst_req_o}, 32'h0);
    @(negedge clk);
    drive(1, 0, 0, 1, 0, 32'h0, 32'hBFC00000);
    #1;
    check("post_rst_req",  {31'b0, inst_req_o}, 32'h1);
    check("post_rst_addr", inst_addr_o,         32'hBFC00000);
    @(negedge clk);
    drive(1, 1, 0, 0, 1, 32'h24010001, 32'hBFC00000);
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 32'h0, 32'hBFC00004);
    #1;
    check("post_rst_valid", {31'b0, inst_valid_o}, 32'h1);
    check("post_rst_inst",  inst_o,                32'h24010001);
    #2;
    rst = 1'b0;
    #1;
    check("arst_full_valid", {31'b0, inst_valid_o}, 32'h0);
    check("arst_full_inst",  inst_o,                32'h0);
    check("arst_full_sreq",  {31'b0, stallreq_o},   32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
